// File: rtl/pipe_mac_power_ctrl_pkg.sv
// Shared encodings for the PIPE MAC power controller: PHY power states,
// controller FSM states and the legal power-transition table.
package pipe_mac_power_ctrl_pkg;

    typedef enum logic [1:0] {
        PWR_P0  = 2'b00,
        PWR_P0S = 2'b01,
        PWR_P1  = 2'b10,
        PWR_P2  = 2'b11
    } pwr_state_t;

    typedef enum logic [1:0] {
        S_RST_WAIT = 2'b00,
        S_IDLE     = 2'b01,
        S_PCHANGE  = 2'b10,
        S_DETECT   = 2'b11
    } pm_state_t;

    // True when the PHY may move directly from cur to nxt (cur != nxt assumed).
    function automatic logic legal_trans(input logic [1:0] cur, input logic [1:0] nxt);
        logic ok;
        ok = 1'b0;
        case (cur)
            PWR_P0:  ok = (nxt == PWR_P0S) || (nxt == PWR_P1) || (nxt == PWR_P2);
            PWR_P0S: ok = (nxt == PWR_P0);
            PWR_P1:  ok = (nxt == PWR_P0) || (nxt == PWR_P2);
            PWR_P2:  ok = (nxt == PWR_P1);
            default: ok = 1'b0;
        endcase
        return ok;
    endfunction

endpackage

// File: rtl/pipe_mac_power_ctrl_pm_timeout_counter.sv
// Saturating wait counter; expired is high once TIMEOUT_CYCLES-1 cycles
// have elapsed since the last clear.
module pm_timeout_counter #(
    parameter int TIMEOUT_CYCLES = 1024,
    parameter int CNT_W          = 11
) (
    input  logic REFCLK,
    input  logic RESET,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    localparam logic [CNT_W-1:0] LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    logic [CNT_W-1:0] cnt;

    always_ff @(posedge REFCLK or posedge RESET) begin
        if (RESET) begin
            cnt <= '0;
        end else if (clear) begin
            cnt <= '0;
        end else if (enable && (cnt != LAST)) begin
            cnt <= cnt + CNT_W'(1);
        end
    end

    assign expired = (cnt == LAST);

endmodule

// File: rtl/pipe_mac_power_ctrl.sv
// MAC-side PIPE power-management controller: issues PWRDDWN / RXDET_LOOPB
// commands and waits for the PHYSTATUS completion handshake.
module pipe_mac_power_ctrl
    import pipe_mac_power_ctrl_pkg::*;
#(
    parameter int         TIMEOUT_CYCLES = 1024,
    parameter int         CNT_W          = 11,
    parameter logic [1:0] RESET_PWR      = 2'b10
) (
    input  logic       REFCLK,
    input  logic       RESET,
    input  logic       REQ_VALID,
    input  logic [1:0] REQ_STATE,
    input  logic       REQ_DETECT,
    output logic       REQ_READY,
    output logic       REQ_ERR,
    output logic       DONE,
    input  logic       PHYSTATUS,
    input  logic       RXDET,
    output logic [1:0] PWRDDWN,
    output logic       RXDET_LOOPB,
    output logic [1:0] CUR_STATE,
    output logic       DET_RESULT,
    output logic       TIMEOUT_ERR,
    input  logic       ERR_CLR
);

    pm_state_t state;
    logic      waiting;
    logic      expired;
    logic      accept;

    // The counter only runs while a PHY handshake is outstanding and is
    // held at zero otherwise, so every wait starts from a fresh count.
    assign waiting = (state == S_PCHANGE) || (state == S_DETECT);
    assign accept  = REQ_VALID && REQ_READY;

    pm_timeout_counter #(
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES),
        .CNT_W          (CNT_W)
    ) u_timeout (
        .REFCLK  (REFCLK),
        .RESET   (RESET),
        .clear   (!waiting),
        .enable  (waiting),
        .expired (expired)
    );

    always_ff @(posedge REFCLK or posedge RESET) begin
        if (RESET) begin
            state       <= S_RST_WAIT;
            PWRDDWN     <= RESET_PWR;
            CUR_STATE   <= RESET_PWR;
            RXDET_LOOPB <= 1'b0;
            REQ_READY   <= 1'b0;
            REQ_ERR     <= 1'b0;
            DONE        <= 1'b0;
            DET_RESULT  <= 1'b0;
            TIMEOUT_ERR <= 1'b0;
        end else begin
            DONE    <= 1'b0;
            REQ_ERR <= 1'b0;
            // A timeout later in this block overrides the clear.
            if (ERR_CLR) TIMEOUT_ERR <= 1'b0;

            case (state)
                S_RST_WAIT: begin
                    if (!PHYSTATUS) begin
                        state     <= S_IDLE;
                        REQ_READY <= 1'b1;
                    end
                end

                S_IDLE: begin
                    if (accept) begin
                        if (REQ_DETECT) begin
                            if (CUR_STATE == PWR_P1) begin
                                RXDET_LOOPB <= 1'b1;
                                REQ_READY   <= 1'b0;
                                state       <= S_DETECT;
                            end else begin
                                REQ_ERR <= 1'b1;
                            end
                        end else if (REQ_STATE == CUR_STATE) begin
                            DONE <= 1'b1;
                        end else if (legal_trans(CUR_STATE, REQ_STATE)) begin
                            PWRDDWN   <= REQ_STATE;
                            REQ_READY <= 1'b0;
                            state     <= S_PCHANGE;
                        end else begin
                            REQ_ERR <= 1'b1;
                        end
                    end
                end

                S_PCHANGE: begin
                    if (PHYSTATUS) begin
                        CUR_STATE <= PWRDDWN;
                        DONE      <= 1'b1;
                        REQ_READY <= 1'b1;
                        state     <= S_IDLE;
                    end else if (expired) begin
                        TIMEOUT_ERR <= 1'b1;
                        PWRDDWN     <= CUR_STATE;
                        RXDET_LOOPB <= 1'b0;
                        REQ_READY   <= 1'b1;
                        state       <= S_IDLE;
                    end
                end

                S_DETECT: begin
                    if (PHYSTATUS) begin
                        DET_RESULT  <= RXDET;
                        RXDET_LOOPB <= 1'b0;
                        DONE        <= 1'b1;
                        REQ_READY   <= 1'b1;
                        state       <= S_IDLE;
                    end else if (expired) begin
                        TIMEOUT_ERR <= 1'b1;
                        PWRDDWN     <= CUR_STATE;
                        RXDET_LOOPB <= 1'b0;
                        REQ_READY   <= 1'b1;
                        state       <= S_IDLE;
                    end
                end

                default: begin
                    state <= S_RST_WAIT;
                end
            endcase
        end
    end

    // Structural invariants of the handshake.
    a_done_err_excl: assert property (@(posedge REFCLK) disable iff (RESET)
        !(DONE && REQ_ERR));
    a_ready_idle: assert property (@(posedge REFCLK) disable iff (RESET)
        REQ_READY == (state == S_IDLE));
    a_loopb_detect: assert property (@(posedge REFCLK) disable iff (RESET)
        RXDET_LOOPB == (state == S_DETECT));

endmodule

// File: tb/tb_pipe_mac_power_ctrl.sv
// Directed bench for pipe_mac_power_ctrl with a short timeout so the
// timeout path can be exercised in a handful of cycles.
module tb_pipe_mac_power_ctrl;

    logic       REFCLK = 1'b0;
    logic       RESET, REQ_VALID, REQ_DETECT, PHYSTATUS, RXDET, ERR_CLR;
    logic [1:0] REQ_STATE;
    logic       REQ_READY, REQ_ERR, DONE, RXDET_LOOPB, DET_RESULT, TIMEOUT_ERR;
    logic [1:0] PWRDDWN, CUR_STATE;

    int pass_cnt  = 0;
    int total_cnt = 0;

    pipe_mac_power_ctrl #(
        .TIMEOUT_CYCLES (8),
        .CNT_W          (4),
        .RESET_PWR      (2'b10)
    ) dut (
        .REFCLK      (REFCLK),
        .RESET       (RESET),
        .REQ_VALID   (REQ_VALID),
        .REQ_STATE   (REQ_STATE),
        .REQ_DETECT  (REQ_DETECT),
        .REQ_READY   (REQ_READY),
        .REQ_ERR     (REQ_ERR),
        .DONE        (DONE),
        .PHYSTATUS   (PHYSTATUS),
        .RXDET       (RXDET),
        .PWRDDWN     (PWRDDWN),
        .RXDET_LOOPB (RXDET_LOOPB),
        .CUR_STATE   (CUR_STATE),
        .DET_RESULT  (DET_RESULT),
        .TIMEOUT_ERR (TIMEOUT_ERR),
        .ERR_CLR     (ERR_CLR)
    );

    always #5 REFCLK = ~REFCLK;

    task automatic tick();
        @(posedge REFCLK);
        #1;
    endtask

    // Legal power change with PHYSTATUS answered in the first cycle.
    task automatic go_state(input logic [1:0] s);
        REQ_VALID = 1'b1; REQ_STATE = s; REQ_DETECT = 1'b0;
        tick();
        REQ_VALID = 1'b0; PHYSTATUS = 1'b1;
        tick();
        PHYSTATUS = 1'b0;
        total_cnt++;
        if (DONE !== 1'b1 || CUR_STATE !== s)
            $display("FAIL go_state done=%b cur=%b exp done=1 cur=%b", DONE, CUR_STATE, s);
        else pass_cnt++;
    endtask

    task automatic test_reset();
        RESET = 1'b1; REQ_VALID = 1'b0; REQ_STATE = 2'b00; REQ_DETECT = 1'b0;
        PHYSTATUS = 1'b1; RXDET = 1'b0; ERR_CLR = 1'b0;
        tick(); tick();
        total_cnt++;
        if ({PWRDDWN, CUR_STATE, RXDET_LOOPB, REQ_READY, REQ_ERR, DONE, DET_RESULT, TIMEOUT_ERR} !== 10'b10_10_000000)
            $display("FAIL reset_vals got pwr=%b cur=%b lb=%b rdy=%b err=%b done=%b det=%b to=%b exp 10/10/0s",
                     PWRDDWN, CUR_STATE, RXDET_LOOPB, REQ_READY, REQ_ERR, DONE, DET_RESULT, TIMEOUT_ERR);
        else pass_cnt++;
        RESET = 1'b0;
        for (int i = 0; i < 20; i++) begin
            tick();
            total_cnt++;
            if (REQ_READY !== 1'b0 || PWRDDWN !== 2'b10)
                $display("FAIL rst_wait cyc=%0d rdy=%b pwr=%b exp rdy=0 pwr=10", i, REQ_READY, PWRDDWN);
            else pass_cnt++;
        end
        PHYSTATUS = 1'b0;
        tick();
        total_cnt++;
        if (REQ_READY !== 1'b1 || PWRDDWN !== 2'b10)
            $display("FAIL rst_release rdy=%b pwr=%b exp rdy=1 pwr=10", REQ_READY, PWRDDWN);
        else pass_cnt++;
    endtask

    task automatic test_p1_to_p0();
        REQ_VALID = 1'b1; REQ_STATE = 2'b00;
        tick();
        REQ_VALID = 1'b0;
        total_cnt++;
        if (PWRDDWN !== 2'b00 || REQ_READY !== 1'b0 || CUR_STATE !== 2'b10 || DONE !== 1'b0)
            $display("FAIL p1p0_accept pwr=%b rdy=%b cur=%b done=%b exp 00/0/10/0", PWRDDWN, REQ_READY, CUR_STATE, DONE);
        else pass_cnt++;
        tick(); tick();
        total_cnt++;
        if (DONE !== 1'b0 || CUR_STATE !== 2'b10)
            $display("FAIL p1p0_wait done=%b cur=%b exp 0/10", DONE, CUR_STATE);
        else pass_cnt++;
        PHYSTATUS = 1'b1;
        tick();
        PHYSTATUS = 1'b0;
        total_cnt++;
        if (DONE !== 1'b1 || CUR_STATE !== 2'b00 || REQ_READY !== 1'b1)
            $display("FAIL p1p0_done done=%b cur=%b rdy=%b exp 1/00/1", DONE, CUR_STATE, REQ_READY);
        else pass_cnt++;
        tick();
        total_cnt++;
        if (DONE !== 1'b0)
            $display("FAIL p1p0_pulse done=%b exp 0", DONE);
        else pass_cnt++;
    endtask

    task automatic test_same_and_idle();
        REQ_VALID = 1'b1; REQ_STATE = 2'b00;
        tick();
        REQ_VALID = 1'b0;
        total_cnt++;
        if (DONE !== 1'b1 || PWRDDWN !== 2'b00 || REQ_READY !== 1'b1)
            $display("FAIL same_state done=%b pwr=%b rdy=%b exp 1/00/1", DONE, PWRDDWN, REQ_READY);
        else pass_cnt++;
        PHYSTATUS = 1'b1;
        tick();
        PHYSTATUS = 1'b0;
        tick();
        total_cnt++;
        if (DONE !== 1'b0 || CUR_STATE !== 2'b00 || REQ_READY !== 1'b1)
            $display("FAIL idle_phystatus done=%b cur=%b rdy=%b exp 0/00/1", DONE, CUR_STATE, REQ_READY);
        else pass_cnt++;
    endtask

    task automatic test_illegal();
        go_state(2'b01);
        REQ_VALID = 1'b1; REQ_STATE = 2'b11;
        tick();
        REQ_VALID = 1'b0;
        total_cnt++;
        if (REQ_ERR !== 1'b1 || PWRDDWN !== 2'b01 || CUR_STATE !== 2'b01 || REQ_READY !== 1'b1 || DONE !== 1'b0)
            $display("FAIL illegal_p0s_p2 err=%b pwr=%b cur=%b rdy=%b done=%b exp 1/01/01/1/0",
                     REQ_ERR, PWRDDWN, CUR_STATE, REQ_READY, DONE);
        else pass_cnt++;
        tick();
        total_cnt++;
        if (REQ_ERR !== 1'b0 || PWRDDWN !== 2'b01)
            $display("FAIL illegal_pulse err=%b pwr=%b exp 0/01", REQ_ERR, PWRDDWN);
        else pass_cnt++;
    endtask

    task automatic test_detect();
        go_state(2'b00);
        go_state(2'b10);
        REQ_VALID = 1'b1; REQ_DETECT = 1'b1; REQ_STATE = 2'b00;
        tick();
        REQ_VALID = 1'b0; REQ_DETECT = 1'b0;
        total_cnt++;
        if (RXDET_LOOPB !== 1'b1 || REQ_READY !== 1'b0 || PWRDDWN !== 2'b10)
            $display("FAIL det_start lb=%b rdy=%b pwr=%b exp 1/0/10", RXDET_LOOPB, REQ_READY, PWRDDWN);
        else pass_cnt++;
        tick();
        total_cnt++;
        if (RXDET_LOOPB !== 1'b1 || DONE !== 1'b0)
            $display("FAIL det_hold lb=%b done=%b exp 1/0", RXDET_LOOPB, DONE);
        else pass_cnt++;
        PHYSTATUS = 1'b1; RXDET = 1'b1;
        tick();
        PHYSTATUS = 1'b0; RXDET = 1'b0;
        total_cnt++;
        if (DET_RESULT !== 1'b1 || RXDET_LOOPB !== 1'b0 || DONE !== 1'b1 || CUR_STATE !== 2'b10)
            $display("FAIL det_done det=%b lb=%b done=%b cur=%b exp 1/0/1/10", DET_RESULT, RXDET_LOOPB, DONE, CUR_STATE);
        else pass_cnt++;
        go_state(2'b00);
        REQ_VALID = 1'b1; REQ_DETECT = 1'b1;
        tick();
        REQ_VALID = 1'b0; REQ_DETECT = 1'b0;
        total_cnt++;
        if (REQ_ERR !== 1'b1 || RXDET_LOOPB !== 1'b0 || DET_RESULT !== 1'b1)
            $display("FAIL det_in_p0 err=%b lb=%b det=%b exp 1/0/1", REQ_ERR, RXDET_LOOPB, DET_RESULT);
        else pass_cnt++;
    endtask

    task automatic test_timeout();
        go_state(2'b10);
        REQ_VALID = 1'b1; REQ_STATE = 2'b11;
        tick();
        REQ_VALID = 1'b0;
        for (int i = 1; i < 8; i++) begin
            tick();
            total_cnt++;
            if (TIMEOUT_ERR !== 1'b0 || PWRDDWN !== 2'b11 || DONE !== 1'b0)
                $display("FAIL to_wait cyc=%0d to=%b pwr=%b done=%b exp 0/11/0", i, TIMEOUT_ERR, PWRDDWN, DONE);
            else pass_cnt++;
        end
        tick();
        total_cnt++;
        if (TIMEOUT_ERR !== 1'b1 || PWRDDWN !== 2'b10 || DONE !== 1'b0 || CUR_STATE !== 2'b10 || REQ_READY !== 1'b1)
            $display("FAIL to_fire to=%b pwr=%b done=%b cur=%b rdy=%b exp 1/10/0/10/1",
                     TIMEOUT_ERR, PWRDDWN, DONE, CUR_STATE, REQ_READY);
        else pass_cnt++;
        tick();
        total_cnt++;
        if (TIMEOUT_ERR !== 1'b1)
            $display("FAIL to_sticky to=%b exp 1", TIMEOUT_ERR);
        else pass_cnt++;
        ERR_CLR = 1'b1;
        tick();
        ERR_CLR = 1'b0;
        total_cnt++;
        if (TIMEOUT_ERR !== 1'b0)
            $display("FAIL to_clear to=%b exp 0", TIMEOUT_ERR);
        else pass_cnt++;
    endtask

    task automatic test_timeout_edges();
        // PHYSTATUS arrives exactly in the terminal count cycle.
        REQ_VALID = 1'b1; REQ_STATE = 2'b11;
        tick();
        REQ_VALID = 1'b0;
        repeat (7) tick();
        PHYSTATUS = 1'b1;
        tick();
        PHYSTATUS = 1'b0;
        total_cnt++;
        if (DONE !== 1'b1 || TIMEOUT_ERR !== 1'b0 || CUR_STATE !== 2'b11)
            $display("FAIL to_last_cycle done=%b to=%b cur=%b exp 1/0/11", DONE, TIMEOUT_ERR, CUR_STATE);
        else pass_cnt++;
        // Timeout and ERR_CLR together: the set wins.
        REQ_VALID = 1'b1; REQ_STATE = 2'b10;
        tick();
        REQ_VALID = 1'b0;
        repeat (7) tick();
        ERR_CLR = 1'b1;
        tick();
        ERR_CLR = 1'b0;
        total_cnt++;
        if (TIMEOUT_ERR !== 1'b1 || PWRDDWN !== 2'b11 || DONE !== 1'b0)
            $display("FAIL to_set_wins to=%b pwr=%b done=%b exp 1/11/0", TIMEOUT_ERR, PWRDDWN, DONE);
        else pass_cnt++;
        ERR_CLR = 1'b1;
        tick();
        ERR_CLR = 1'b0;
    endtask

    task automatic test_reset_mid_detect();
        go_state(2'b10);
        REQ_VALID = 1'b1; REQ_DETECT = 1'b1;
        tick();
        REQ_VALID = 1'b0; REQ_DETECT = 1'b0;
        total_cnt++;
        if (RXDET_LOOPB !== 1'b1)
            $display("FAIL rst_det_pre lb=%b exp 1", RXDET_LOOPB);
        else pass_cnt++;
        #2 RESET = 1'b1;
        #1;
        total_cnt++;
        if (RXDET_LOOPB !== 1'b0 || PWRDDWN !== 2'b10 || REQ_READY !== 1'b0 || DET_RESULT !== 1'b0)
            $display("FAIL rst_async lb=%b pwr=%b rdy=%b det=%b exp 0/10/0/0", RXDET_LOOPB, PWRDDWN, REQ_READY, DET_RESULT);
        else pass_cnt++;
        tick();
        RESET = 1'b0;
        tick();
        total_cnt++;
        if (REQ_READY !== 1'b1 || CUR_STATE !== 2'b10)
            $display("FAIL rst_recover rdy=%b cur=%b exp 1/10", REQ_READY, CUR_STATE);
        else pass_cnt++;
    endtask

    initial begin
        test_reset();
        test_p1_to_p0();
        test_same_and_idle();
        test_illegal();
        test_detect();
        test_timeout();
        test_timeout_edges();
        test_reset_mid_detect();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule

// File: doc/pipe_mac_power_ctrl.md
Name: pipe_mac_power_ctrl

Overview:
MAC-side controller for the PHY power-management interface. It drives PWRDDWN and RXDET_LOOPB toward the PHY power manager, then waits for the PHYSTATUS completion handshake. It also sequences receiver-detect requests and captures the PHY's RXDET result. It sits between link-layer control logic, which uses a valid/ready request port, and the PHY.

Parameters:
TIMEOUT_CYCLES, 1024, cycles to wait for PHYSTATUS before declaring timeout (>=2)
CNT_W, 11, timeout counter width; must hold TIMEOUT_CYCLES-1
RESET_PWR, 2'b10, PWRDDWN value driven during and after reset (P1)

Ports:
REFCLK  input  1  sole clock, rising edge
RESET  input  1  asynchronous, active-high reset
REQ_VALID  input  1  request strobe from link layer
REQ_STATE  input  2  requested power state (P0=00, P0s=01, P1=10, P2=11)
REQ_DETECT  input  1  1 = receiver-detect request (REQ_STATE ignored)
REQ_READY  output  1  controller accepts request this cycle
REQ_ERR  output  1  1-cycle pulse: illegal request rejected
DONE  output  1  1-cycle pulse: power change or detect completed
PHYSTATUS  input  1  PHY completion pulse; held high by PHY until ready after reset
RXDET  input  1  PHY receiver-detect result, valid with PHYSTATUS
PWRDDWN  output  2  power state command to PHY
RXDET_LOOPB  output  1  receiver-detect request to PHY
CUR_STATE  output  2  last acknowledged power state
DET_RESULT  output  1  last captured receiver-detect result
TIMEOUT_ERR  output  1  sticky; PHYSTATUS never arrived
ERR_CLR  input  1  clears TIMEOUT_ERR

Behaviour:
- Reset values: PWRDDWN=RESET_PWR, CUR_STATE=RESET_PWR, RXDET_LOOPB=0, REQ_READY=0, REQ_ERR=0, DONE=0, DET_RESULT=0, TIMEOUT_ERR=0, FSM=S_RST_WAIT, counter=0.
- All outputs are registered. Asserting RESET mid-operation aborts immediately to the reset values.
- S_RST_WAIT: stay here while PHYSTATUS=1. The first cycle PHYSTATUS is sampled 0 -> S_IDLE. No timeout applies in this state.
- S_IDLE: REQ_READY=1. A request is accepted when REQ_VALID=1 and REQ_READY=1.
- Legal transitions:
  - from P0: P0s, P1, P2
  - from P0s: P0
  - from P1: P0, P2
  - from P2: P1
- Same-state request (REQ_STATE==CUR_STATE): DONE pulses the next cycle. No PWRDDWN change, no PHY handshake.
- Illegal transition, or REQ_DETECT=1 while CUR_STATE!=P1: REQ_ERR pulses the next cycle, state stays S_IDLE, nothing changes.
- Legal change: the next cycle PWRDDWN=REQ_STATE, REQ_READY=0, FSM -> S_PCHANGE, counter cleared.
- Legal detect: the next cycle RXDET_LOOPB=1, FSM -> S_DETECT, counter cleared.
- S_PCHANGE: the counter increments every cycle. When PHYSTATUS is sampled 1, the next cycle gives:
  - CUR_STATE=PWRDDWN
  - DONE pulse
  - FSM -> S_IDLE
- S_DETECT: when PHYSTATUS is sampled 1, the next cycle gives:
  - DET_RESULT=RXDET (sampled in the same cycle as PHYSTATUS)
  - RXDET_LOOPB=0
  - DONE pulse
  - FSM -> S_IDLE
- Timeout: the counter reaches TIMEOUT_CYCLES-1 with PHYSTATUS=0. The next cycle gives:
  - TIMEOUT_ERR=1
  - PWRDDWN reverts to CUR_STATE; RXDET_LOOPB=0
  - no DONE
  - FSM -> S_IDLE
- PHYSTATUS=1 in the terminal timeout cycle counts as completion, not timeout.
- PHYSTATUS pulses in S_IDLE are ignored.
- ERR_CLR=1 clears TIMEOUT_ERR the next cycle. If a timeout and ERR_CLR occur in the same cycle, the set wins.
- Minimum latency from request to DONE is 2 cycles, with PHYSTATUS high in the first cycle after acceptance.

Decomposition:
- Shared package: power state encodings PWR_P0/P0S/P1/P2 (shared with power_manager), FSM state encodings S_RST_WAIT/S_IDLE/S_PCHANGE/S_DETECT, and a legal-transition function.
- One sub-module, pm_timeout_counter, with:
  - inputs: clear, enable
  - output: expired
  - parameterised by TIMEOUT_CYCLES/CNT_W
  - clock/reset as the parent

Test Plan:
- Reset with PHYSTATUS held 1 for 20 cycles, then 0 -> REQ_READY rises the cycle after PHYSTATUS is sampled 0; PWRDDWN=10 throughout.
- From P1, request P0; PHY pulses PHYSTATUS 3 cycles later -> PWRDDWN=00 one cycle after accept, DONE one cycle after PHYSTATUS, CUR_STATE=00.
- From P0, request P0s, then from P0s request P2 -> first completes; second gives a REQ_ERR pulse, and PWRDDWN/CUR_STATE stay 01.
- In P1, detect request; PHYSTATUS=1 with RXDET=1 -> RXDET_LOOPB high until PHYSTATUS, DET_RESULT=1, DONE pulse; detect request in P0 -> REQ_ERR.
- TIMEOUT_CYCLES=8, request P2 from P1, no PHYSTATUS -> TIMEOUT_ERR=1 after 8 cycles, PWRDDWN back to 10, no DONE; ERR_CLR clears it.
- Assert RESET while in S_DETECT -> RXDET_LOOPB=0 and PWRDDWN=10 immediately, without waiting for a clock edge.
